// File: rtl/muldiv_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_seq_ctrl_pkg
//   Shared definitions for the iterative M-extension sequencer: FSM state
//   encoding, unit select and op codes, and small decode helpers used by the
//   sequencer and the control unit.
// -----------------------------------------------------------------------------
package muldiv_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Unit select (muldiv_sel)
  localparam logic SEL_MUL = 1'b0;
  localparam logic SEL_DIV = 1'b1;

  // Multiply op codes
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  // Divide op codes
  localparam logic [1:0] OP_DIV    = 2'b00;
  localparam logic [1:0] OP_DIVU   = 2'b01;
  localparam logic [1:0] OP_REM    = 2'b10;
  localparam logic [1:0] OP_REMU   = 2'b11;

  // Operand A is treated as signed. MUL only keeps the low product word,
  // which is identical for signed and unsigned operands, so it runs unsigned.
  function automatic logic rs1_is_signed(input logic sel, input logic [1:0] op);
    if (sel == SEL_MUL) return (op == OP_MULH) || (op == OP_MULHSU);
    else                return (op == OP_DIV)  || (op == OP_REM);
  endfunction

  function automatic logic rs2_is_signed(input logic sel, input logic [1:0] op);
    if (sel == SEL_MUL) return (op == OP_MULH);
    else                return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // REM/REMU return the remainder word, DIV/DIVU the quotient.
  function automatic logic div_wants_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_seq_ctrl_fixup.sv
// -----------------------------------------------------------------------------
// muldiv_seq_ctrl_fixup
//   Combinational post-processing for the iterative multiply/divide unit.
//   Applies sign correction to the unsigned magnitude result, forces the
//   architectural results for divide-by-zero and signed overflow, and selects
//   the requested 32-bit word.
//
// Ports
//   sel_i       unit select (SEL_MUL / SEL_DIV)
//   op_i        op code within the selected unit
//   acc_i       mul: 2*XLEN magnitude product; div: {remainder, quotient}
//   neg_res_i   negate product / quotient
//   neg_rem_i   negate remainder (follows dividend sign)
//   div_zero_i  divisor was zero
//   ovf_i       signed overflow (most negative / -1)
//   result_o    final result word
// -----------------------------------------------------------------------------
module muldiv_seq_ctrl_fixup
  import muldiv_seq_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              sel_i,
  input  logic [1:0]        op_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic              neg_res_i,
  input  logic              neg_rem_i,
  input  logic              div_zero_i,
  input  logic              ovf_i,
  output logic [XLEN-1:0]   result_o
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    prod     = neg_res_i ? -acc_i : acc_i;
    quot     = neg_res_i ? -acc_i[XLEN-1:0] : acc_i[XLEN-1:0];
    rem      = neg_rem_i ? -acc_i[2*XLEN-1:XLEN] : acc_i[2*XLEN-1:XLEN];
    result_o = '0;

    // The restoring divider already leaves the dividend in the remainder for
    // a zero divisor; only the quotient needs forcing. Overflow is forced
    // outright so it does not depend on the wrap behaviour of the negation.
    if (div_zero_i) begin
      quot = '1;
    end else if (ovf_i) begin
      quot = {1'b1, {(XLEN-1){1'b0}}};
      rem  = '0;
    end

    if (sel_i == SEL_MUL) begin
      result_o = (op_i == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else begin
      result_o = div_wants_rem(op_i) ? rem : quot;
    end
  end

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_seq_ctrl
//   Sequencer for the shared iterative M-extension unit in the EX stage.
//   Radix-2 shift-add multiply or restoring divide, one bit per cycle, on
//   operand magnitudes; sign correction and word select happen in FIX.
//   Flow: IDLE -> CALC (XLEN cycles) -> FIX -> DONE -> IDLE.
//   Stalls the pipeline while an op is outstanding and returns one registered
//   result per accepted op with a one-cycle done_o pulse.
//
// Configuration
//   MULDIV_FASTPATH_EN  when defined, divide-by-zero and signed overflow go
//                       straight from IDLE to DONE with the result loaded on
//                       the accept edge. Undefined: full latency, same values.
//
// Ports
//   clk_i     core clock, rising edge
//   reset_i   asynchronous active-low reset
//   start_i   op request (level, held while stall_o=1)
//   sel_i     0 = multiply, 1 = divide
//   op_i      op code (see muldiv_seq_ctrl_pkg)
//   rs1_i     operand A / dividend
//   rs2_i     operand B / divisor
//   flush_i   aborts an op in IDLE/CALC/FIX
//   stall_o   hold IF/ID/EX while the op is outstanding
//   busy_o    FSM not in IDLE
//   done_o    one-cycle pulse, result_o valid
//   result_o  registered result, held until the next completion
// -----------------------------------------------------------------------------
module muldiv_seq_ctrl
  import muldiv_seq_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            sel_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e state, state_nxt;

  // Datapath registers
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;
  logic [CNT_W-1:0]  cnt;
  logic              neg_res;
  logic              neg_rem;
  logic              div_zero;
  logic              ovf;
  logic              sel_q;
  logic [1:0]        op_q;

  // ---------------------------------------------------------------------------
  // Operand decode in IDLE
  // ---------------------------------------------------------------------------
  logic            accept;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero_in, ovf_in;

  assign accept      = (state == ST_IDLE) && start_i && !flush_i;
  assign a_neg       = rs1_is_signed(sel_i, op_i) && rs1_i[XLEN-1];
  assign b_neg       = rs2_is_signed(sel_i, op_i) && rs2_i[XLEN-1];
  assign a_mag       = a_neg ? -rs1_i : rs1_i;
  assign b_mag       = b_neg ? -rs2_i : rs2_i;
  assign div_zero_in = (sel_i == SEL_DIV) && (rs2_i == '0);
  assign ovf_in      = (sel_i == SEL_DIV) && rs2_is_signed(sel_i, op_i) &&
                       (rs1_i == MOST_NEG) && (rs2_i == '1);

`ifdef MULDIV_FASTPATH_EN
  logic            special_in;
  logic [XLEN-1:0] special_res;

  assign special_in = div_zero_in || ovf_in;

  always_comb begin
    special_res = '0;
    if (div_zero_in) special_res = div_wants_rem(op_i) ? rs1_i : '1;
    else             special_res = div_wants_rem(op_i) ? '0 : MOST_NEG;
  end
`endif

  // ---------------------------------------------------------------------------
  // One iteration of the datapath
  //   mul: acc = {product_hi, multiplier}; add B when the multiplier LSB is
  //        set, then shift the whole thing right (carry enters at the top).
  //   div: acc = {remainder, dividend/quotient}; shift left, trial-subtract
  //        the divisor from the widened remainder, quotient bit = no borrow.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    div_trial = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_trial - {1'b0, opb};
    acc_step  = acc;
    if (sel_q == SEL_MUL) begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

  logic [XLEN-1:0] fix_result;

  muldiv_seq_ctrl_fixup #(
    .XLEN(XLEN)
  ) u_fixup (
    .sel_i      (sel_q),
    .op_i       (op_q),
    .acc_i      (acc),
    .neg_res_i  (neg_res),
    .neg_rem_i  (neg_rem),
    .div_zero_i (div_zero),
    .ovf_i      (ovf),
    .result_o   (fix_result)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
`ifdef MULDIV_FASTPATH_EN
          state_nxt = special_in ? ST_DONE : ST_CALC;
`else
          state_nxt = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        if (flush_i)                            state_nxt = ST_IDLE;
        else if (cnt == CNT_W'(XLEN-1))         state_nxt = ST_FIX;
      end
      ST_FIX:  state_nxt = flush_i ? ST_IDLE : ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;   // flush ignored, no re-accept here
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs. stall_o is gated by reset so the pipeline is released
  // while reset is asserted, even before the state register settles.
  always_comb begin
    stall_o = reset_i && (accept || (state == ST_CALC) || (state == ST_FIX));
    busy_o  = (state != ST_IDLE);
    done_o  = (state == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      acc      <= '0;
      opb      <= '0;
      cnt      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      sel_q    <= SEL_MUL;
      op_q     <= 2'b00;
      result_o <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            acc      <= {{XLEN{1'b0}}, a_mag};
            opb      <= b_mag;
            cnt      <= '0;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= div_zero_in;
            ovf      <= ovf_in;
            sel_q    <= sel_i;
            op_q     <= op_i;
`ifdef MULDIV_FASTPATH_EN
            if (special_in) result_o <= special_res;
`endif
          end
        end
        ST_CALC: begin
          if (!flush_i) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;   // wraps to 0 after the last iteration
          end
        end
        ST_FIX: begin
          if (!flush_i) result_o <= fix_result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq_ctrl
//   Self-checking bench for muldiv_seq_ctrl. Expected results are pushed to a
//   scoreboard queue when an op is driven and compared when done_o pulses.
// -----------------------------------------------------------------------------
module tb_muldiv_seq_ctrl;
  import muldiv_seq_ctrl_pkg::*;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            start_i;
  logic            sel_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  muldiv_seq_ctrl #(.XLEN(XLEN), .CNT_W(5)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .sel_i    (sel_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_result;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Independent reference model using wide native arithmetic.
  function automatic logic [31:0] ref_model(input logic s, input logic [1:0] o,
                                            input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s == SEL_MUL) begin
      case (o)
        OP_MUL:    p = {32'h0, a} * {32'h0, b};
        OP_MULH:   p = 64'(sa * sb);
        OP_MULHSU: p = 64'(sa * longint'({32'h0, b}));
        default:   p = {32'h0, a} * {32'h0, b};
      endcase
      return (o == OP_MUL) ? p[31:0] : p[63:32];
    end
    if (b == 32'h0) return (o == OP_REM || o == OP_REMU) ? a : 32'hFFFF_FFFF;
    if (o == OP_DIV || o == OP_REM) begin
      sq = sa / sb;
      sr = sa % sb;
    end else begin
      sq = longint'({32'h0, a}) / longint'({32'h0, b});
      sr = longint'({32'h0, a}) % longint'({32'h0, b});
    end
    return (o == OP_REM || o == OP_REMU) ? sr[31:0] : sq[31:0];
  endfunction

  // Drive one op, push its expected result, wait (bounded) for done_o.
  task automatic run_op(input string tag, input logic s, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    logic special;
    int   exp_lat, lat;
    bit   seen;
    logic [31:0] want;
    special = (s == SEL_DIV) &&
              ((b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MULDIV_FASTPATH_EN
    exp_lat = special ? 1 : 34;
`else
    exp_lat = 34;
    special = 1'b0;
`endif
    @(negedge clk_i);
    start_i = 1'b1; sel_i = s; op_i = o; rs1_i = a; rs2_i = b;
    exp_q.push_back(exp);
    #1 check({tag, "_stall_accept"}, 32'(stall_o), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk_i);
      @(negedge clk_i);
      lat++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    want = exp_q.pop_front();
    if (seen) begin
      check({tag, "_result"}, result_o, want);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_stall_done"}, 32'(stall_o), 32'd0);
      last_result = want;
    end
  endtask

  initial begin
    reset_i = 1'b0; start_i = 1'b0; sel_i = 1'b0; op_i = 2'b00;
    rs1_i = '0; rs2_i = '0; flush_i = 1'b0; last_result = '0;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    start_i = 1'b1;   // stall must stay low under reset even with a request
    #1 check("rst_stall_req", 32'(stall_o), 32'd0);
    start_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_result", result_o, 32'd0);

    // Directed vectors
    run_op("mul_7x-3",   SEL_MUL, OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulh_min",   SEL_MUL, OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhsu_ff",  SEL_MUL, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhu_ff",   SEL_MUL, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("div_-7_2",   SEL_DIV, OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_op("rem_-7_2",   SEL_DIV, OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_op("divu_100_7", SEL_DIV, OP_DIVU,   32'd100,       32'd7,         32'd14);
    run_op("remu_100_7", SEL_DIV, OP_REMU,   32'd100,       32'd7,         32'd2);
    run_op("divu_5_0",   SEL_DIV, OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF);
    run_op("rem_5_0",    SEL_DIV, OP_REM,    32'd5,         32'd0,         32'd5);
    run_op("div_ovf",    SEL_DIV, OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",    SEL_DIV, OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("div_-5_0",   SEL_DIV, OP_DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF);

    // Flush and start in the same IDLE cycle: nothing accepted
    @(negedge clk_i);
    start_i = 1'b1; flush_i = 1'b1; sel_i = SEL_MUL; op_i = OP_MUL;
    rs1_i = 32'd3; rs2_i = 32'd4;
    #1 check("flush_start_stall", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    check("flush_start_busy", 32'(busy_o), 32'd0);
    start_i = 1'b0; flush_i = 1'b0;

    // Flush at CALC cycle 10
    @(negedge clk_i);
    start_i = 1'b1; sel_i = SEL_MUL; op_i = OP_MULHU; rs1_i = 32'h1234_5678; rs2_i = 32'h9ABC_DEF0;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    check("flush_pre_busy", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush_stall", 32'(stall_o), 32'd0);
    check("flush_busy", 32'(busy_o), 32'd0);
    check("flush_result_held", result_o, last_result);
    begin
      int pulses;
      pulses = 0;
      repeat (40) begin
        @(negedge clk_i);
        if (done_o) pulses++;
      end
      check("flush_no_done", 32'(pulses), 32'd0);
    end
    run_op("after_flush", SEL_DIV, OP_DIVU, 32'd1000, 32'd33, 32'd30);

    // Async reset at CALC cycle 20
    @(negedge clk_i);
    start_i = 1'b1; sel_i = SEL_DIV; op_i = OP_DIV; rs1_i = 32'd12345; rs2_i = 32'd67;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (19) @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_done", 32'(done_o), 32'd0);
    check("arst_result", result_o, 32'd0);
    check("arst_stall", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b1;
    last_result = '0;
    run_op("b2b_0", SEL_MUL, OP_MULH, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
    run_op("b2b_1", SEL_DIV, OP_REMU, 32'd77, 32'd10, 32'd7);

    // Randomised ops against the reference model
    for (int k = 0; k < 8; k++) begin
      logic s;
      logic [1:0] o;
      logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      o = 2'($urandom_range(0, 3));
      a = $urandom();
      b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom();
      if (k == 3) b = 32'd1;
      run_op($sformatf("rand%0d", k), s, o, a, b, ref_model(s, o, a, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
